// File: rtl/dmac_channel_dpath.sv
// rtl/dmac_channel_dpath.sv - DMA channel datapath: address, transfer-size and burst-beat counters (optional DMAC_ADDR_FIX_EN)
module dmac_channel_dpath #(
    parameter int ADDR_W = 32,
    parameter int TS_W   = 16,
    parameter int BS_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cfg_src_addr,
    input  logic [ADDR_W-1:0] cfg_dst_addr,
    input  logic [TS_W-1:0]   cfg_trans_size,
    input  logic [BS_W-1:0]   cfg_burst_size,
    input  logic [1:0]        cfg_hsize,
    input  logic              cfg_src_fix,
    input  logic              cfg_dst_fix,
    input  logic              t_sel,
    input  logic              d_sel,
    input  logic              s_sel,
    input  logic              b_sel,
    input  logic              h_sel,
    input  logic              ts_en,
    input  logic              burst_en,
    input  logic              count_en,
    input  logic              sz_en,
    input  logic              s_en,
    input  logic              d_en,
    output logic [ADDR_W-1:0] haddr,
    output logic [2:0]        hsize,
    output logic              tsz,
    output logic              bsz,
    output logic              tslb,
    output logic [TS_W-1:0]   remaining
);

    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [TS_W-1:0]   ts_q;
    logic [BS_W-1:0]   blen_q;
    logic [BS_W-1:0]   beat_q;
    logic [1:0]        hsz_q;

    logic [ADDR_W-1:0] addr_inc;
    logic [TS_W-1:0]   blen_ext;
    logic [TS_W-1:0]   ts_dec;
    logic [BS_W-1:0]   burst_load;
    logic              src_hold;
    logic              dst_hold;

    // A fixed address (e.g. a peripheral FIFO) keeps its value across beats; loads still apply.
`ifdef DMAC_ADDR_FIX_EN
    assign src_hold = cfg_src_fix;
    assign dst_hold = cfg_dst_fix;
`else
    // Fix inputs stay on the port list but have no effect in this build.
    assign src_hold = cfg_src_fix & 1'b0;
    assign dst_hold = cfg_dst_fix & 1'b0;
`endif

    assign addr_inc   = ADDR_W'(1) << hsz_q;
    assign blen_ext   = TS_W'(blen_q);
    // Remaining count never underflows: a short tail burst drives it to zero.
    assign ts_dec     = (ts_q > blen_ext) ? (ts_q - blen_ext) : '0;
    // A zero burst size is treated as single-beat bursts.
    assign burst_load = (cfg_burst_size == '0) ? BS_W'(1) : cfg_burst_size;

    // Address counters: load from config or step by the beat size.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q <= '0;
            dst_q <= '0;
        end else begin
            if (s_en) begin
                if (s_sel)
                    src_q <= cfg_src_addr;
                else if (!src_hold)
                    src_q <= src_q + addr_inc;
            end
            if (d_en) begin
                if (d_sel)
                    dst_q <= cfg_dst_addr;
                else if (!dst_hold)
                    dst_q <= dst_q + addr_inc;
            end
        end
    end

    // Transfer-size and beat-size registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_q  <= '0;
            hsz_q <= '0;
        end else begin
            if (ts_en)
                ts_q <= t_sel ? cfg_trans_size : ts_dec;
            if (sz_en)
                hsz_q <= cfg_hsize;
        end
    end

    // Burst length and beat counter; a new burst restarts the beat count ahead of any count pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blen_q <= BS_W'(1);
            beat_q <= '0;
        end else if (burst_en) begin
            blen_q <= b_sel ? BS_W'(ts_q) : burst_load;
            beat_q <= '0;
        end else if (count_en) begin
            beat_q <= bsz ? '0 : beat_q + BS_W'(1);
        end
    end

    assign haddr     = h_sel ? dst_q : src_q;
    assign hsize     = {1'b0, hsz_q};
    assign tsz       = (ts_q == '0);
    assign bsz       = (beat_q == blen_q - BS_W'(1));
    assign tslb      = (ts_q != '0) && (ts_q < blen_ext);
    assign remaining = ts_q;

endmodule

// File: doc/dmac_channel_dpath.md
DMAC_CHANNEL_DPATH -- requirements
Module: dmac_channel_dpath

Interface
REQ-001 SHALL have parameters (name, default, meaning): ADDR_W, 32, address width; TS_W, 16, transfer-size counter width; BS_W, 8, burst-length width.
REQ-002 SHALL have ports (name direction width meaning): clk in 1 clock; rst in 1 reset, asynchronous, active-high.
REQ-003 cfg_src_addr in ADDR_W source start address; cfg_dst_addr in ADDR_W destination start address.
REQ-004 cfg_trans_size in TS_W total beats; cfg_burst_size in BS_W beats per burst; cfg_hsize in 2 beat size, log2 bytes.
REQ-005 cfg_src_fix in 1 hold source address; cfg_dst_fix in 1 hold destination address.
REQ-006 t_sel, d_sel, s_sel, b_sel, h_sel in 1 each: load/update and address selects from channel_ctrl.
REQ-007 ts_en, burst_en, count_en, sz_en, s_en, d_en in 1 each: register enables from channel_ctrl.
REQ-008 haddr out ADDR_W bus address; hsize out 3 beat size; tsz out 1 transfer remaining is zero; bsz out 1 current beat is last of burst; tslb out 1 remaining less than burst; remaining out TS_W beats left.

Function
REQ-009 SHALL hold registers src_q, dst_q (ADDR_W), ts_q (TS_W), blen_q (BS_W), beat_q (BS_W), hsz_q (2); all updates on posedge clk only.
REQ-010 sz_en: hsz_q <= cfg_hsize; hsize = {1'b0, hsz_q}; address increment = 1 << hsz_q (1, 2, 4 or 8 bytes).
REQ-011 s_en & s_sel: src_q <= cfg_src_addr; s_en & !s_sel: src_q <= src_q + increment, modulo 2^ADDR_W (wraps without flag).
REQ-012 d_en & d_sel: dst_q <= cfg_dst_addr; d_en & !d_sel: dst_q <= dst_q + increment, modulo 2^ADDR_W.
REQ-013 ts_en & t_sel: ts_q <= cfg_trans_size; ts_en & !t_sel: ts_q <= ts_q - blen_q, saturating at 0.
REQ-014 burst_en & !b_sel: blen_q <= cfg_burst_size, where 0 loads as 1; burst_en & b_sel: blen_q <= ts_q truncated to BS_W (tail-burst shortening).
REQ-015 burst_en also clears beat_q to 0; burst_en SHALL take priority over a coincident count_en.
REQ-016 count_en & !bsz: beat_q <= beat_q + 1; count_en & bsz: beat_q <= 0 (wrap at burst end).
REQ-017 Outputs are combinational from registers only; zero cycles of latency from a register update to its flag.
REQ-018 tsz = (ts_q == 0); bsz = (beat_q == blen_q - 1); tslb = (ts_q != 0) & (ts_q < blen_q); remaining = ts_q.
REQ-019 haddr = h_sel ? dst_q : src_q; switching h_sel takes effect in the same cycle.
REQ-020 Simultaneous enables are independent per register; one register never has two writers in one cycle.
REQ-021 With all enables low, every register SHALL hold its value (the HOLD_READ/HOLD_WRITE pause).

Reset
REQ-022 rst high SHALL asynchronously clear src_q, dst_q, ts_q, beat_q, hsz_q to 0 and set blen_q to 1.
REQ-023 Post-reset outputs: haddr 0, hsize 0, tsz 1, bsz 1, tslb 0, remaining 0.
REQ-024 rst asserted mid-transfer SHALL abandon all counts; no state survives reset.

Configuration
REQ-025 Macro DMAC_ADDR_FIX_EN: when defined, cfg_src_fix / cfg_dst_fix high suppress the increment of REQ-011 / REQ-012 (load still occurs).
REQ-026 Without DMAC_ADDR_FIX_EN: the fix ports remain present but are ignored; addresses always increment.

Verification
REQ-027 Load src 0x1000, dst 0x2000, hsize 2, three src increments -> haddr 0x100C (h_sel 0), 0x2000 (h_sel 1).
REQ-028 trans_size 10, burst 4: after two ts_en decrements ts_q = 2, tslb 1; burst_en & b_sel -> blen_q 2; one more decrement -> tsz 1.
REQ-029 burst 4, four count_en pulses -> bsz high on the fourth beat (beat_q 3), then beat_q 0; burst_size 0 loads -> blen_q 1, bsz constantly 1.
REQ-030 src 0xFFFF_FFFC, hsize 2, increment -> src_q 0x0000_0000; ts_q 3, blen 4, decrement -> ts_q 0, not 0xFFFF.
REQ-031 With DMAC_ADDR_FIX_EN and cfg_dst_fix 1: five d_en increments -> dst stays 0x2000; macro undefined -> 0x2014.
REQ-032 rst pulse mid-burst (beat_q 2, ts_q 7) -> all registers are at reset values immediately, with no clock edge required.
